// File: rtl/sd_write_photo_pkg.sv
// Shared SD write-path constants and sequencer state encoding.
// Also imported by the photo read sequencer so both sides agree on sector geometry.
package sd_write_photo_pkg;

    typedef logic [31:0] sec_addr_t;

    localparam sec_addr_t   PHOTO_ADDR0_DEF    = 32'd8256;
    localparam sec_addr_t   PHOTO_ADDR1_DEF    = 32'd9792;
    localparam logic [10:0] WR_SECTION_NUM_DEF = 11'd1500;
    localparam logic [8:0]  SEC_WORDS_DEF      = 9'd256;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    function automatic sec_addr_t slot_base(input logic slot, input sec_addr_t addr0,
                                            input sec_addr_t addr1);
        return slot ? addr1 : addr0;
    endfunction

endpackage

// File: rtl/sd_write_photo_if.sv
// Pixel FIFO read side plus SD controller write port, as seen by the photo sequencer.
interface sd_write_photo_if;
    logic [10:0] fifo_rdusedw;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        wr_busy;
    logic        wr_req;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic [15:0] wr_data;

    modport master (
        input  fifo_rdusedw, fifo_rd_data, wr_busy, wr_req,
        output fifo_rd_en, wr_start_en, wr_sec_addr, wr_data
    );

    modport slave (
        output fifo_rdusedw, fifo_rd_data, wr_busy, wr_req,
        input  fifo_rd_en, wr_start_en, wr_sec_addr, wr_data
    );
endinterface

// File: rtl/sd_write_photo_edge_neg_det.sv
// Two-flop falling-edge detector with a registered one-cycle pulse output.
// A fall of sig in cycle n yields fall high in cycle n+2.
module edge_neg_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic fall
);
    logic busy_d0_reg;
    logic busy_d1_reg;
    logic fall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_d0_reg <= 1'b0;
            busy_d1_reg <= 1'b0;
            fall_reg    <= 1'b0;
        end else begin
            busy_d0_reg <= sig;
            busy_d1_reg <= busy_d0_reg;
            fall_reg    <= busy_d1_reg & ~busy_d0_reg;
        end
    end

    assign fall = fall_reg;
endmodule

// File: rtl/sd_write_photo.sv
// Frame-to-SD sector write sequencer: waits for a full sector in the pixel FIFO,
// starts a sector write, feeds words on each controller request, repeats per frame.
module sd_write_photo
    import sd_write_photo_pkg::*;
#(
    parameter sec_addr_t   PHOTO_SECTION_ADDR0 = PHOTO_ADDR0_DEF,
    parameter sec_addr_t   PHOTO_SECTION_ADDR1 = PHOTO_ADDR1_DEF,
    parameter logic [10:0] WR_SECTION_NUM      = WR_SECTION_NUM_DEF,
    parameter logic [8:0]  SEC_WORDS           = SEC_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_start,
    input  logic              cap_slot,
    sd_write_photo_if.master  sd,
    output logic              photo_busy,
    output logic              photo_done,
    output logic              err_ovf
);
    logic [2:0]  state_reg, state_next;
    sec_addr_t   addr_reg;
    logic [10:0] sec_cnt_reg;
    logic [8:0]  word_cnt_reg;
    logic        err_ovf_reg;
    logic        busy_fall;
    logic        in_write;
    logic        room;

    edge_neg_det u_busy_fall (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sd.wr_busy),
        .fall  (busy_fall)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (cap_start) state_next = ST_WAIT_DATA;
            // A whole sector must be buffered so the FIFO cannot underflow mid-sector.
            ST_WAIT_DATA: if (sd.fifo_rdusedw >= 11'(SEC_WORDS)) state_next = ST_START;
            ST_START:     state_next = ST_WRITE;
            ST_WRITE: begin
                if (busy_fall)
                    state_next = (sec_cnt_reg == WR_SECTION_NUM - 11'd1) ? ST_DONE : ST_WAIT_DATA;
            end
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            sec_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            err_ovf_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (cap_start) begin
                        addr_reg    <= slot_base(cap_slot, PHOTO_SECTION_ADDR0, PHOTO_SECTION_ADDR1);
                        sec_cnt_reg <= '0;
                        err_ovf_reg <= 1'b0;
                    end
                end
                ST_START: word_cnt_reg <= '0;
                ST_WRITE: begin
                    if (sd.wr_req) begin
                        if (room) word_cnt_reg <= word_cnt_reg + 9'd1;
                        else      err_ovf_reg  <= 1'b1;
                    end
                    if (busy_fall) begin
                        addr_reg    <= addr_reg + 32'd1;
                        sec_cnt_reg <= sec_cnt_reg + 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_write = (state_reg == ST_WRITE);
    assign room     = (word_cnt_reg < SEC_WORDS);

    // Same-cycle acknowledge keeps the show-ahead FIFO aligned with the word the controller samples.
    assign sd.fifo_rd_en  = in_write & room & sd.wr_req;
    assign sd.wr_data     = (in_write & room) ? sd.fifo_rd_data : 16'd0;
    assign sd.wr_start_en = (state_reg == ST_START);
    assign sd.wr_sec_addr = addr_reg;

    assign photo_busy = (state_reg != ST_IDLE);
    assign photo_done = (state_reg == ST_DONE);
    assign err_ovf    = err_ovf_reg;
endmodule

// File: tb/tb_sd_write_photo.sv
// Randomized bench for sd_write_photo: FIFO and SD controller models plus a frame-level reference.
module tb_sd_write_photo;
    localparam int NSEC   = 3;
    localparam int WORDS  = 256;
    localparam int A0     = 8256;
    localparam int A1     = 9792;

    logic clk = 1'b0;
    logic rst_n, cap_start, cap_slot;
    logic photo_busy, photo_done, err_ovf;

    sd_write_photo_if sd ();

    sd_write_photo #(.WR_SECTION_NUM(11'd3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_start  (cap_start),
        .cap_slot   (cap_slot),
        .sd         (sd.master),
        .photo_busy (photo_busy),
        .photo_done (photo_done),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // FIFO model (show-ahead)
    logic [15:0] fq[$];
    logic [15:0] exp_q[$];
    bit pop_now;

    task automatic fifo_refresh();
        sd.fifo_rdusedw = (fq.size() > 2047) ? 11'd2047 : 11'(fq.size());
        sd.fifo_rd_data = (fq.size() > 0) ? fq[0] : 16'd0;
    endtask

    task automatic push_words(input int n);
        logic [15:0] w;
        for (int k = 0; k < n; k++) begin
            w = 16'($urandom);
            fq.push_back(w);
            exp_q.push_back(w);
        end
        fifo_refresh();
    endtask

    task automatic flush_fifo();
        fq.delete();
        exp_q.delete();
        fifo_refresh();
    endtask

    always @(posedge clk) begin
        pop_now = sd.fifo_rd_en;
        #1;
        if (pop_now && fq.size() > 0) void'(fq.pop_front());
        fifo_refresh();
    end

    // SD controller model
    int ctrl_reqs = WORDS;
    int fall_cyc[$];
    initial begin
        sd.wr_busy = 1'b0;
        sd.wr_req  = 1'b0;
        forever begin
            @(negedge clk);
            if (sd.wr_start_en) begin
                @(posedge clk); #1 sd.wr_busy = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                for (int k = 0; k < ctrl_reqs; k++) begin
                    if (!rst_n) break;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    sd.wr_req = 1'b1;
                    @(posedge clk); #1;
                    sd.wr_req = 1'b0;
                end
                repeat (2) @(posedge clk);
                #1 sd.wr_busy = 1'b0;
                fall_cyc.push_back(cyc);
            end
        end
    end

    // Monitor
    int          starts_addr[$];
    int          starts_cyc[$];
    logic [15:0] rx_q[$];
    int rd_cnt, bad_cnt, done_cnt, done_cyc, busy_rise_cyc, busy_after_done;
    bit prev_done;

    task automatic clear_mon();
        starts_addr.delete(); starts_cyc.delete(); rx_q.delete(); fall_cyc.delete();
        rd_cnt = 0; bad_cnt = 0; done_cnt = 0; done_cyc = -1;
        busy_rise_cyc = -1; busy_after_done = -1; prev_done = 0;
    endtask

    always @(negedge clk) begin
        if (sd.wr_start_en) begin
            starts_addr.push_back(int'(sd.wr_sec_addr));
            starts_cyc.push_back(cyc);
        end
        if (sd.fifo_rd_en) rd_cnt++;
        if (sd.wr_req) begin
            if (sd.fifo_rd_en) rx_q.push_back(sd.wr_data);
            else if (sd.wr_data !== 16'd0) bad_cnt++;
        end
        if (sd.fifo_rd_en && !sd.wr_req) bad_cnt++;
        if (prev_done) busy_after_done = int'(photo_busy);
        if (photo_busy && busy_rise_cyc < 0) busy_rise_cyc = cyc;
        if (photo_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_done = photo_done;
    end

    int cap_cyc;
    task automatic do_cap(input bit slot);
        @(posedge clk); #1;
        cap_start = 1'b1;
        cap_slot  = slot;
        cap_cyc   = cyc;
        @(posedge clk); #1;
        cap_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int data_mismatch(input int n);
        int m = 0;
        if (rx_q.size() != n) m++;
        for (int k = 0; k < n; k++)
            if (k >= rx_q.size() || k >= exp_q.size() || rx_q[k] !== exp_q[k]) m++;
        return m;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; cap_start = 1'b0; cap_slot = 1'b0;
        flush_fifo();
        repeat (3) @(negedge clk);
        checks++; if (sd.wr_start_en !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", sd.wr_start_en); end
        checks++; if (sd.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", sd.fifo_rd_en); end
        checks++; if (sd.wr_sec_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", sd.wr_sec_addr); end
        checks++; if (sd.wr_data !== 16'd0) begin errors++; $display("FAIL reset_data got %h want 0", sd.wr_data); end
        checks++; if ({photo_busy, photo_done, err_ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {photo_busy, photo_done, err_ovf}); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_frame_slot0();
        bit ok;
        flush_fifo(); push_words(2048); clear_mon();
        do_cap(1'b0);
        wait_done(6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame0_timeout got no photo_done want done"); end
        checks++; if (starts_cyc.size() < 1 || starts_cyc[0] - cap_cyc != 2) begin errors++; $display("FAIL frame0_start_latency got %0d want 2", starts_cyc.size() ? starts_cyc[0] - cap_cyc : -1); end
        checks++; if (busy_rise_cyc - cap_cyc != 1) begin errors++; $display("FAIL frame0_busy_rise got %0d want 1", busy_rise_cyc - cap_cyc); end
        checks++; if (starts_addr.size() != NSEC) begin errors++; $display("FAIL frame0_nstart got %0d want %0d", starts_addr.size(), NSEC); end
        for (int s = 0; s < NSEC && s < starts_addr.size(); s++) begin
            checks++; if (starts_addr[s] != A0 + s) begin errors++; $display("FAIL frame0_addr%0d got %0d want %0d", s, starts_addr[s], A0 + s); end
        end
        checks++; if (rd_cnt != NSEC * WORDS) begin errors++; $display("FAIL frame0_rd_cnt got %0d want %0d", rd_cnt, NSEC * WORDS); end
        checks++; if (data_mismatch(NSEC * WORDS) != 0) begin errors++; $display("FAIL frame0_data got %0d mismatches want 0", data_mismatch(NSEC * WORDS)); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame0_done_cnt got %0d want 1", done_cnt); end
        checks++; if (fall_cyc.size() != NSEC || done_cyc - fall_cyc[NSEC-1] != 3) begin errors++; $display("FAIL frame0_done_lat got %0d want 3", fall_cyc.size() == NSEC ? done_cyc - fall_cyc[NSEC-1] : -1); end
        checks++; if (busy_after_done != 0) begin errors++; $display("FAIL frame0_busy_after_done got %0d want 0", busy_after_done); end
        checks++; if (fall_cyc.size() < 1 || starts_cyc.size() < 2 || starts_cyc[1] - fall_cyc[0] < 4) begin errors++; $display("FAIL frame0_next_start got %0d want >=4", (fall_cyc.size() && starts_cyc.size() > 1) ? starts_cyc[1] - fall_cyc[0] : -1); end
        checks++; if (err_ovf !== 1'b0 || bad_cnt != 0) begin errors++; $display("FAIL frame0_ovf got %b/%0d want 0/0", err_ovf, bad_cnt); end
    endtask

    task automatic test_slot1_wait();
        bit ok;
        int p;
        flush_fifo(); push_words(WORDS - 1); clear_mon();
        do_cap(1'b1);
        repeat (100) @(posedge clk);
        #1;
        checks++; if (starts_addr.size() != 0) begin errors++; $display("FAIL slot1_early_start got %0d want 0", starts_addr.size()); end
        checks++; if (photo_busy !== 1'b1) begin errors++; $display("FAIL slot1_busy got %b want 1", photo_busy); end
        p = cyc;
        push_words(NSEC * WORDS - (WORDS - 1));
        wait_done(6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL slot1_timeout got no photo_done want done"); end
        checks++; if (starts_cyc.size() < 1 || starts_cyc[0] != p + 1) begin errors++; $display("FAIL slot1_start_cyc got %0d want %0d", starts_cyc.size() ? starts_cyc[0] : -1, p + 1); end
        checks++; if (starts_addr.size() != NSEC || starts_addr[0] != A1 || starts_addr[NSEC-1] != A1 + NSEC - 1) begin errors++; $display("FAIL slot1_addr got %0d want %0d", starts_addr.size() ? starts_addr[0] : -1, A1); end
        checks++; if (data_mismatch(NSEC * WORDS) != 0) begin errors++; $display("FAIL slot1_data got %0d mismatches want 0", data_mismatch(NSEC * WORDS)); end
    endtask

    task automatic test_overflow();
        bit ok;
        flush_fifo(); push_words(1024); clear_mon();
        ctrl_reqs = WORDS + 1;
        do_cap(1'b0);
        wait_done(6000, ok);
        ctrl_reqs = WORDS;
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got no photo_done want done"); end
        checks++; if (rd_cnt != NSEC * WORDS) begin errors++; $display("FAIL ovf_rd_cnt got %0d want %0d", rd_cnt, NSEC * WORDS); end
        checks++; if (bad_cnt != 0) begin errors++; $display("FAIL ovf_extra_data got %0d bad words want 0", bad_cnt); end
        checks++; if (data_mismatch(NSEC * WORDS) != 0) begin errors++; $display("FAIL ovf_data got %0d mismatches want 0", data_mismatch(NSEC * WORDS)); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", err_ovf); end
    endtask

    task automatic test_ignore_cap();
        bit ok;
        flush_fifo(); push_words(1024); clear_mon();
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ign_err_held got %b want 1", err_ovf); end
        do_cap(1'b0);
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ign_err_clear got %b want 0", err_ovf); end
        repeat (50) @(posedge clk);
        #1 cap_start = 1'b1; cap_slot = 1'b1;
        @(posedge clk); #1 cap_start = 1'b0;
        wait_done(6000, ok);
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL ign_done got %0d want 1", done_cnt); end
        checks++; if (starts_addr.size() != NSEC || starts_addr[0] != A0 || starts_addr[NSEC-1] != A0 + NSEC - 1) begin errors++; $display("FAIL ign_addr got %0d starts first %0d want %0d from %0d", starts_addr.size(), starts_addr.size() ? starts_addr[0] : -1, NSEC, A0); end
        checks++; if (rd_cnt != NSEC * WORDS) begin errors++; $display("FAIL ign_rd_cnt got %0d want %0d", rd_cnt, NSEC * WORDS); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        flush_fifo(); push_words(2048); clear_mon();
        do_cap(1'b0);
        for (int i = 0; i < 3000 && starts_addr.size() < 2; i++) @(negedge clk);
        checks++; if (starts_addr.size() != 2) begin errors++; $display("FAIL abort_reach_sec2 got %0d starts want 2", starts_addr.size()); end
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({sd.wr_start_en, sd.fifo_rd_en, photo_busy, photo_done, err_ovf} !== 5'b0 ||
                sd.wr_sec_addr !== 32'd0 || sd.wr_data !== 16'd0) begin
                errors++;
                $display("FAIL abort_in_reset got addr %0d flags %b want 0", sd.wr_sec_addr,
                         {sd.wr_start_en, sd.fifo_rd_en, photo_busy, photo_done, err_ovf});
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        flush_fifo(); push_words(1024); clear_mon();
        do_cap(1'b0);
        wait_done(6000, ok);
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL abort_restart_done got %0d want 1", done_cnt); end
        checks++; if (starts_addr.size() != NSEC || starts_addr[0] != A0 || starts_addr[NSEC-1] != A0 + NSEC - 1) begin errors++; $display("FAIL abort_restart_addr got %0d starts first %0d want %0d from %0d", starts_addr.size(), starts_addr.size() ? starts_addr[0] : -1, NSEC, A0); end
        checks++; if (data_mismatch(NSEC * WORDS) != 0) begin errors++; $display("FAIL abort_restart_data got %0d mismatches want 0", data_mismatch(NSEC * WORDS)); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        test_reset();
        test_frame_slot0();
        test_slot1_wait();
        test_overflow();
        test_ignore_cap();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
